// File: rtl/ifu_pkg.sv
// Shared fetch-stage types and constants.
// Decode imports the same bus offsets.
package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_SEND,
    S_WAIT_NPC,
    S_ERR
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  localparam int IF_ID_INST_LSB = 0;
  localparam int IF_ID_PC_LSB   = DATA_W_DEF;

endpackage

// File: rtl/ifu.sv
// Instruction fetch stage: one fetch in flight,
// {pc,inst} to decode, next pc taken back from decode.
module ifu
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             if_to_id_valid,
  input  logic                             id_to_if_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] if_to_id_bus,
  input  logic                             id_to_if_valid,
  output logic                             if_to_id_ready,
  input  logic [ADDR_WIDTH-1:0]            id_to_if_bus,
  output logic                             imem_req_valid,
  input  logic                             imem_req_ready,
  output logic [ADDR_WIDTH-1:0]            imem_req_addr,
  input  logic                             imem_rsp_valid,
  output logic                             imem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]            imem_rsp_data,
  input  logic                             imem_rsp_err,
  output logic                             fetch_err,
  output logic [63:0]                      inst_cnt
);

  ifu_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst;
  logic [63:0]           cnt;
  logic                  misalign;

  assign misalign = |pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake decodes
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    if_to_id_valid = 1'b0;
    if_to_id_ready = 1'b0;
    fetch_err      = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = !misalign;
        if (misalign)
          state_nxt = S_ERR;
        else if (imem_req_ready)
          state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        imem_rsp_ready = 1'b1;
        if (imem_rsp_valid)
          state_nxt = imem_rsp_err ? S_ERR
                                   : S_SEND;
      end
      S_SEND: begin
        if_to_id_valid = 1'b1;
        if (id_to_if_ready)
          state_nxt = S_WAIT_NPC;
      end
      S_WAIT_NPC: begin
        if_to_id_ready = 1'b1;
        if (id_to_if_valid)
          state_nxt = S_REQ;
      end
      S_ERR: fetch_err = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pc, instruction and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      inst <= '0;
      cnt  <= '0;
    end else begin
      if (imem_rsp_ready && imem_rsp_valid
          && !imem_rsp_err)
        inst <= imem_rsp_data;
      if (if_to_id_valid && id_to_if_ready)
        cnt <= cnt + 64'd1;
      if (if_to_id_ready && id_to_if_valid)
        pc <= id_to_if_bus;
    end
  end

  assign imem_req_addr = pc;
  assign if_to_id_bus  = {pc, inst};
  assign inst_cnt      = cnt;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for the fetch stage.
// Expected {pc,inst} queued at response, popped at decode.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_to_id_valid;
  logic        id_to_if_ready = 1'b0;
  logic [63:0] if_to_id_bus;
  logic        id_to_if_valid = 1'b0;
  logic        if_to_id_ready;
  logic [31:0] id_to_if_bus = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        fetch_err;
  logic [63:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  logic [63:0] exp_cnt = '0;
  logic [63:0] exp_q[$];

  ifu dut (
    .clk(clk),
    .rst(rst),
    .if_to_id_valid(if_to_id_valid),
    .id_to_if_ready(id_to_if_ready),
    .if_to_id_bus(if_to_id_bus),
    .id_to_if_valid(id_to_if_valid),
    .if_to_id_ready(if_to_id_ready),
    .id_to_if_bus(id_to_if_bus),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .fetch_err(fetch_err),
    .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({if_to_id_valid, if_to_id_ready,
         imem_req_valid, imem_rsp_ready,
         fetch_err} !== 5'b0 || inst_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: hs=%b err=%b cnt=%0d want 0",
        {if_to_id_valid, if_to_id_ready,
         imem_req_valid, imem_rsp_ready},
        fetch_err, inst_cnt);
    end
    rst = 1'b0;
    rel_cyc = cyc;
    exp_cnt = '0;
    exp_q.delete();
  endtask

  task automatic mem_fetch(input logic [31:0] addr,
                           input logic [31:0] data,
                           input bit err,
                           input int stall,
                           input int lat);
    int n = 0;
    while (!imem_req_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!imem_req_valid) begin
      errors++;
      $display("FAIL req_timeout: req_valid=0 want 1");
      return;
    end
    checks++;
    if (imem_req_addr !== addr) begin
      errors++;
      $display("FAIL req_addr: got %h want %h",
        imem_req_addr, addr);
    end
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      tick();
      checks++;
      if (imem_req_valid !== 1'b1
          || imem_req_addr !== addr) begin
        errors++;
        $display("FAIL req_stall: v=%b a=%h want 1 %h",
          imem_req_valid, imem_req_addr, addr);
      end
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < lat; i++) begin
      tick();
      checks++;
      if (imem_rsp_ready !== 1'b1) begin
        errors++;
        $display("FAIL rsp_ready_wait: got %b want 1",
          imem_rsp_ready);
      end
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    checks++;
    if (imem_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_ready: got %b want 1",
        imem_rsp_ready);
    end
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    if (!err) exp_q.push_back({addr, data});
  endtask

  task automatic deliver(input int hold);
    logic [63:0] exp;
    logic [63:0] held;
    int n = 0;
    while (!if_to_id_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!if_to_id_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL deliver_timeout: valid=%b q=%0d",
        if_to_id_valid, exp_q.size());
      return;
    end
    exp = exp_q.pop_front();
    held = if_to_id_bus;
    for (int i = 0; i < hold; i++) begin
      id_to_if_ready = 1'b0;
      tick();
      checks++;
      if (if_to_id_valid !== 1'b1
          || if_to_id_bus !== held
          || inst_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL bus_hold: v=%b bus=%h cnt=%0d want 1 %h %0d",
          if_to_id_valid, if_to_id_bus, inst_cnt,
          held, exp_cnt);
      end
    end
    checks++;
    if (if_to_id_bus !== exp) begin
      errors++;
      $display("FAIL bus_value: got %h want %h",
        if_to_id_bus, exp);
    end
    id_to_if_ready = 1'b1;
    tick();
    id_to_if_ready = 1'b0;
    exp_cnt = exp_cnt + 64'd1;
    checks++;
    if (inst_cnt !== exp_cnt || if_to_id_valid !== 1'b0
        || if_to_id_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: cnt=%0d v=%b r=%b want %0d 0 1",
        inst_cnt, if_to_id_valid, if_to_id_ready, exp_cnt);
    end
  endtask

  task automatic send_npc(input logic [31:0] npc,
                          input int delay,
                          input bit poke);
    for (int i = 0; i < delay; i++) begin
      imem_rsp_valid = poke;
      tick();
      checks++;
      if (if_to_id_ready !== 1'b1 || imem_req_valid !== 1'b0
          || imem_rsp_ready !== 1'b0) begin
        errors++;
        $display("FAIL npc_wait: r=%b req=%b rspr=%b want 1 0 0",
          if_to_id_ready, imem_req_valid, imem_rsp_ready);
      end
    end
    imem_rsp_valid = 1'b0;
    id_to_if_valid = 1'b1;
    id_to_if_bus   = npc;
    tick();
    id_to_if_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req_valid, if_to_id_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_outputs: got %b want 00",
        {imem_req_valid, if_to_id_valid});
    end
  endtask

  task automatic test_first_fetch();
    mem_fetch(32'h8000_0000, 32'h0000_0413, 0, 0, 0);
    checks++;
    if (if_to_id_valid !== 1'b1 || cyc - rel_cyc != 3) begin
      errors++;
      $display("FAIL first_latency: v=%b cycles=%0d want 1 3",
        if_to_id_valid, cyc - rel_cyc);
    end
    deliver(5);
  endtask

  task automatic test_dnpc();
    send_npc(32'h8000_0010, 3, 1);
    checks++;
    if (imem_req_valid !== 1'b1
        || imem_req_addr !== 32'h8000_0010) begin
      errors++;
      $display("FAIL dnpc_req: v=%b a=%h want 1 80000010",
        imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_req_stall();
    mem_fetch(32'h8000_0010, 32'h0010_0093, 0, 4, 2);
    deliver(0);
  endtask

  task automatic test_rsp_err();
    send_npc(32'h8000_0014, 0, 0);
    mem_fetch(32'h8000_0014, 32'hdead_beef, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fetch_err !== 1'b1 || {if_to_id_valid,
          if_to_id_ready, imem_req_valid,
          imem_rsp_ready} !== 4'b0
          || imem_req_addr !== 32'h8000_0014) begin
        errors++;
        $display("FAIL err_halt: err=%b hs=%b pc=%h",
          fetch_err, {if_to_id_valid, if_to_id_ready,
          imem_req_valid, imem_rsp_ready}, imem_req_addr);
      end
      id_to_if_ready = 1'b1;
      tick();
    end
    id_to_if_ready = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    mem_fetch(32'h8000_0000, 32'h0000_0013, 0, 0, 0);
    deliver(0);
    send_npc(32'h8000_0002, 1, 0);
    imem_req_ready = 1'b1;
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_req: v=%b err=%b want 0 0",
        imem_req_valid, fetch_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0
          || imem_req_addr !== 32'h8000_0002) begin
        errors++;
        $display("FAIL misalign_err: err=%b v=%b pc=%h",
          fetch_err, imem_req_valid, imem_req_addr);
      end
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_fetch(32'h8000_0000, 32'h0000_0413, 0, 0, 0);
    deliver(1);
    send_npc(32'h8000_0020, 0, 0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++;
    if (imem_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_rsp: rspr=%b want 1",
        imem_rsp_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rel_cyc = cyc;
    exp_cnt = '0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_0bad;
    checks++;
    if (imem_rsp_ready !== 1'b0 || inst_cnt !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: rspr=%b cnt=%0d want 0 0",
        imem_rsp_ready, inst_cnt);
    end
    tick();
    imem_rsp_valid = 1'b0;
    mem_fetch(32'h8000_0000, 32'h0000_0513, 0, 0, 0);
    deliver(0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_dnpc();
    test_req_stall();
    test_rsp_err();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
